// File: rtl/score_bcd_scanner_pkg.sv
// Shared constants and helpers for the BCD score counter and digit scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
package score_pkg;

  localparam int           BCD_W           = 4;
  localparam logic [3:0]   BCD_MAX         = 4'd9;
  localparam int           MAX_DIGITS      = 8;
  // 100 MHz clock / 100000 gives a 1 kHz digit slot rate.
  localparam int           SCAN_DIV_100MHZ = 100000;

  // One-hot-low anode mask for a digit index; callers keep the low DIGITS bits.
  function automatic logic [MAX_DIGITS-1:0] an_mask(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/score_bcd_scanner_if.sv
// Bus between game control / display pins and the score scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (affects an_n only).
//
// Handshake: there is no valid/ready pair on this bus. inc is a one-cycle
// pulse that is either consumed on the edge it is sampled or dropped
// (freeze, clr or saturation); there is no backpressure and nothing queues.
// clr and freeze are level inputs sampled every rising edge. All outputs are
// registered and valid every cycle outside reset.
interface score_bcd_scanner_if #(
  parameter int DIGITS = 4
) ();

  logic                  inc;
  logic                  clr;
  logic                  freeze;
  logic [4*DIGITS-1:0]   score;
  logic                  sat;
  logic [3:0]            bcd_out;
  logic [DIGITS-1:0]     an_n;

  modport master (
    output inc, clr, freeze,
    input  score, sat, bcd_out, an_n
  );

  modport slave (
    input  inc, clr, freeze,
    output score, sat, bcd_out, an_n
  );

endinterface

// File: rtl/score_bcd_scanner_bcd_digit_counter.sv
// One BCD digit of the score: counts 0..9 on en, wraps and signals carry.
// Optional feature macro: LEADING_ZERO_BLANK_EN (not used here).
module bcd_digit_counter
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  // Digit register: clear wins, then hold, then count with 9 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en && !hold) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 1'b1;
    end
  end

  assign carry_out = en & (digit == BCD_MAX);

endmodule

// File: rtl/score_bcd_scanner.sv
// Saturating packed-BCD score counter plus multiplexed 7-segment digit scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, digit slots
// above the most significant non-zero digit are kept dark (digit 0 always lit).
module score_bcd_scanner
  import score_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = SCAN_DIV_100MHZ
) (
  input  logic               clk,
  input  logic               rst_n,
  score_bcd_scanner_if.slave bus
);

  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]       en;
  logic [DIGITS-1:0]       carry;
  logic [4*DIGITS-1:0]     digits;
  logic                    sat_q;
  logic                    almost_sat;
  logic                    top_carry_unused;
  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              nibble;
  logic [DIGITS-1:0]       an_next;
  logic [3:0]              bcd_q;
  logic [DIGITS-1:0]       an_q;

  // Saturation stops counting at all-nines, so the top carry never fires.
  assign en[0]            = bus.inc & ~bus.freeze & ~sat_q;
  assign top_carry_unused = carry[DIGITS-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (bus.clr),
      .en        (en[g]),
      .hold      (bus.freeze),
      .digit     (digits[g*BCD_W +: BCD_W]),
      .carry_out (carry[g])
    );
    if (g > 0) begin : g_chain
      assign en[g] = carry[g-1];
    end
  end

  // Detect the one increment that lands on all-nines (x..x98 -> x..x99 form).
  always_comb begin
    almost_sat = (digits[BCD_W-1:0] == 4'd8);
    for (int k = 1; k < DIGITS; k++) begin
      almost_sat = almost_sat & (digits[k*BCD_W +: BCD_W] == BCD_MAX);
    end
  end

  // sat tracks all-nines on the same edge the score reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (bus.clr) begin
      sat_q <= 1'b0;
    end else if (en[0] && almost_sat) begin
      sat_q <= 1'b1;
    end
  end

  // Slot timer and digit index; independent of score activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (prescaler == PS_W'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      idx       <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;
  logic blank;
`endif

  // Select the scanned nibble and its anode pattern for the output register.
  always_comb begin
    nibble = '0;
`ifdef LEADING_ZERO_BLANK_EN
    upper_zero = 1'b1;
    blank      = 1'b0;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero = upper_zero & (digits[k*BCD_W +: BCD_W] == '0);
`endif
      if (IDX_W'(k) == idx) begin
        nibble = digits[k*BCD_W +: BCD_W];
`ifdef LEADING_ZERO_BLANK_EN
        blank  = (k != 0) && upper_zero;
`endif
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    an_next = blank ? '1 : DIGITS'(an_mask(3'(idx)));
`else
    an_next = DIGITS'(an_mask(3'(idx)));
`endif
  end

  // Nibble and anode load on the same edge so the display never shows a mixed pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      an_q  <= DIGITS'(an_mask(3'd0));
    end else begin
      bcd_q <= nibble;
      an_q  <= an_next;
    end
  end

  assign bus.score   = digits;
  assign bus.sat     = sat_q;
  assign bus.bcd_out = bcd_q;
  assign bus.an_n    = an_q;

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Testbench for score_bcd_scanner (DIGITS=4, SCAN_DIV=4).
// Honors LEADING_ZERO_BLANK_EN the same way as the design.
module tb_score_bcd_scanner;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int MAX_SCORE = 9999;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  score_bcd_scanner_if #(.DIGITS(D)) bus ();

  score_bcd_scanner #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  int         m_score;
  int         m_cnt;
  int         m_idx;
  logic [3:0] e_bcd;
  logic [3:0] e_an;

  // Model: decimal score, a cycle counter for slot timing, displays digit of old score.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0;
      m_cnt   = 0;
      m_idx   = 0;
      e_bcd   = 4'd0;
      e_an    = 4'b1110;
    end else begin
      e_bcd = 4'((m_score / pow10(m_idx)) % 10);
      e_an  = ~(4'b0001 << m_idx);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && m_score < pow10(m_idx)) e_an = 4'b1111;
`endif
      if (bus.clr) m_score = 0;
      else if (!bus.freeze && bus.inc && m_score < MAX_SCORE) m_score = m_score + 1;
      m_cnt = m_cnt + 1;
      if (m_cnt == SD) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % D;
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("score", bus.score, to_bcd(m_score));
    check("sat", bus.sat, (m_score == MAX_SCORE));
    check("bcd_out", bus.bcd_out, e_bcd);
    check("an_n", bus.an_n, e_an);
`ifndef LEADING_ZERO_BLANK_EN
    check("an_onehot", $countones(~bus.an_n), 1);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.inc = 1'b1;
    end
    @(negedge clk);
    bus.inc = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic load(input int v);
    do_clr();
    if (v > 0) pulse_inc(v);
  endtask

  logic [3:0] an_tab [4];
  logic [3:0] bcd_tab [4];
  int         n_dark, n_lit0, n_lit1;
  bit         found;

  initial begin
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    bcd_tab[0] = 4'd4;   bcd_tab[1] = 4'd3;   bcd_tab[2] = 4'd2;   bcd_tab[3] = 4'd1;
    rst_n = 1'b0;
    bus.inc = 1'b0; bus.clr = 1'b0; bus.freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_score", bus.score, 16'h0000);
    check("rst_sat", bus.sat, 1'b0);
    check("rst_an", bus.an_n, 4'b1110);
    check("rst_bcd", bus.bcd_out, 4'd0);
    #2 rst_n = 1'b1;

    // Idle scan sequence, each slot 4 clocks, wrapping back to digit 0.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("idle_an", bus.an_n, an_tab[(i / 4) % 4]);
      check("idle_bcd", bus.bcd_out, 4'd0);
    end

    // Mid-count reset restarts the scan at digit 0.
    pulse_inc(3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_score", bus.score, 16'h0000);
    check("midrst_an", bus.an_n, 4'b1110);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_scan", bus.an_n, an_tab[i / 4]);
    end

    // Carry ripple.
    load(99);
    check("ld99", bus.score, 16'h0099);
    pulse_inc(1);
    check("carry_0100", bus.score, 16'h0100);
    load(999);
    pulse_inc(1);
    check("carry_1000", bus.score, 16'h1000);

    // Saturation.
    load(9998);
    check("sat_pre", bus.sat, 1'b0);
    pulse_inc(1);
    check("sat_9999", bus.score, 16'h9999);
    check("sat_flag", bus.sat, 1'b1);
    pulse_inc(2);
    check("sat_hold", bus.score, 16'h9999);
    check("sat_flag2", bus.sat, 1'b1);
    do_clr();
    check("sat_clr", bus.sat, 1'b0);

    // Priority: clr > freeze > inc.
    load(42);
    @(negedge clk);
    bus.clr = 1'b1; bus.inc = 1'b1; bus.freeze = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.inc = 1'b0; bus.freeze = 1'b0;
    check("clr_wins", bus.score, 16'h0000);
    load(42);
    bus.freeze = 1'b1;
    pulse_inc(5);
    check("freeze_hold", bus.score, 16'h0042);
    bus.freeze = 1'b0;
    pulse_inc(1);
    check("unfreeze_inc", bus.score, 16'h0043);

    // Scan data for 0x1234.
    load(1234);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      found = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (bus.an_n == an_tab[j]) begin
          found = 1'b1;
          check("scan1234", bus.bcd_out, bcd_tab[j]);
        end
      end
      if (!found) check("scan1234_an", bus.an_n, 4'b1110);
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Leading zero blanking for 0x0070 and 0x0000.
    load(70);
    @(negedge clk);
    n_dark = 0; n_lit0 = 0; n_lit1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.an_n == 4'b1111) n_dark++;
      if (bus.an_n == 4'b1110 && bus.bcd_out == 4'd0) n_lit0++;
      if (bus.an_n == 4'b1101 && bus.bcd_out == 4'd7) n_lit1++;
    end
    check("blank70_dark", n_dark, 8);
    check("blank70_d0", n_lit0, 4);
    check("blank70_d1", n_lit1, 4);
    load(0);
    @(negedge clk);
    n_dark = 0; n_lit0 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.an_n == 4'b1111) n_dark++;
      if (bus.an_n == 4'b1110 && bus.bcd_out == 4'd0) n_lit0++;
    end
    check("blank0_dark", n_dark, 12);
    check("blank0_d0", n_lit0, 4);
`endif

    // Randomized traffic checked by the scoreboard every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.inc    = 1'($urandom_range(0, 1));
      bus.freeze = ($urandom_range(0, 7) == 0);
      bus.clr    = ($urandom_range(0, 299) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    bus.inc = 1'b0; bus.freeze = 1'b0; bus.clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the sequence is bounded; this only guards against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/score_bcd_scanner.md
Name: score_bcd_scanner

Overview:
- Multi-digit BCD score counter plus time-multiplexed digit scanner for the T-rex game score display.
- Counts game-tick score pulses in packed BCD and saturates at all-nines.
- Each scan slot, presents one 4-bit BCD nibble to the downstream BCD-to-7-segment decoder, together with the matching active-low anode select.
- Sits between game control logic (score pulses, restart, game-over) and the 7-segment decoder/anode pins.

Parameters:
- DIGITS, 4: number of BCD digits displayed and counted (1..8).
- SCAN_DIV, 100000: clk cycles per digit slot (≥2); 100000 at 100 MHz gives a 1 kHz digit rate.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inc  input  1  score pulse; one-cycle high adds 1 to the score.
- clr  input  1  synchronous clear of the score (game restart).
- freeze  input  1  game-over hold; while high, inc is ignored.
- score  output  4*DIGITS  packed BCD score; digit 0 (units) in [3:0].
- sat  output  1  high while score equals all-nines.
- bcd_out  output  4  BCD nibble of the currently scanned digit, fed to the decoder.
- an_n  output  DIGITS  active-low digit enable, one-hot-low.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - score = 0, sat = 0
  - prescaler = 0, digit index = 0
  - bcd_out = 0
  - an_n = all ones except bit 0 = 0
- Score update, registered, 1-cycle latency: inc sampled high at edge n gives new score visible after edge n.
  - Priority per cycle: clr > freeze > inc.
  - clr=1: score ← 0, sat ← 0, regardless of inc or freeze.
  - freeze=1 and clr=0: score holds; inc is dropped, not queued.
  - inc=1: digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit, ripple within the same cycle.
  - Saturation: at all-nines, inc leaves score unchanged (no wrap to 0). sat is high whenever score is all-nines, registered alongside score.
  - Digits never hold values 10..15. Arithmetic is strictly 4-bit BCD per digit.
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances by 1, wrapping from DIGITS-1 to 0.
  - bcd_out and an_n are registered. Each edge they load the nibble of score and the one-hot-low select for the current index. They therefore lag an index change or score change by one cycle.
  - an_n always has exactly one bit low. Glitch-free: the anode switch and its nibble change on the same edge.
  - clr, inc and freeze do not disturb the scan timing.
- Reset mid-operation: everything returns to reset values immediately. The scan restarts at digit 0 on the first edge after release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - For the scanned digit k>0: if digit k and every higher digit are 0, an_n drives all ones (digit dark) for that slot.
  - Digit 0 is never blanked, so score 0 shows a single "0".
  - bcd_out still carries the nibble.
  - Blank decision is registered with an_n, same 1-cycle lag.
- Undefined: all digits are always lit, zeros shown.

Decomposition:
- Shared package score_pkg:
  - BCD_W = 4, BCD_MAX = 4'd9.
  - Function returning the one-hot-low anode mask for an index.
  - Default SCAN_DIV for 100 MHz.
- Sub-module bcd_digit_counter: one 4-bit digit.
  - Inputs: clk, rst_n, clr, en (carry-in), hold.
  - Outputs: digit, carry_out (= en & digit==9).
  - Instantiated DIGITS times in a generate loop.
  - Top level gates en with inc, ~freeze, ~sat.

Test Plan:
- Reset/idle (DIGITS=4, SCAN_DIV=4): hold rst_n low mid-count, release → score=0x0000, sat=0, an_n cycles 1110→1101→1011→0111→1110, switching every 4 clk, bcd_out=0.
- Carry ripple: from 0x0099, one inc → score=0x0100 next cycle. From 0x0999, one inc → 0x1000.
- Saturation: from 0x9998, three incs → 0x9999 after the first, sat=1, and score stays 0x9999 after the rest.
- Priority: clr=1 with inc=1 at 0x0042 → 0x0000. freeze=1 with inc pulses ×5 at 0x0042 → 0x0042. Release freeze, inc ×1 → 0x0043.
- Scan data: score=0x1234 → over one full scan, bcd_out/an_n pairs are (4,1110), (3,1101), (2,1011), (1,0111), each held 4 clk.
- LEADING_ZERO_BLANK_EN defined, score=0x0070 → slots for digits 3 and 2 show an_n=1111. Digit 1 shows (7,1101). Digit 0 shows (0,1110). Score 0x0000 lights digit 0 only.
